reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every architectural register.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (x0..x31).
REQ-003 SHALL have parameter REG_AW, default 5, register-address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port wb_we  input  1  write-back enable from the write-back stage.
REQ-007 SHALL have port wb_rd  input  REG_AW  write-back destination register.
REQ-008 SHALL have port wb_data  input  XLEN  write-back data.
REQ-009 SHALL have port rs1_addr  input  REG_AW  read port 1 address.
REQ-010 SHALL have port rs2_addr  input  REG_AW  read port 2 address.
REQ-011 SHALL have port rs1_data  output  XLEN  read port 1 data.
REQ-012 SHALL have port rs2_data  output  XLEN  read port 2 data.
REQ-013 SHALL have port iss_valid  input  1  decode stage presents an instruction for issue.
REQ-014 SHALL have port iss_werf  input  1  issuing instruction writes a register.
REQ-015 SHALL have port iss_rd  input  REG_AW  issuing instruction's destination.
REQ-016 SHALL have port stall  output  1  issue blocked this cycle.
REQ-017 SHALL have port sb_err  output  1  sticky flag: write-back to a register not marked pending.

Function
REQ-018 SHALL hold NREG x XLEN register array plus one pending (busy) bit per register.
REQ-019 SHALL read x0 as zero; writes to x0 ignored; busy[0] permanently 0.
REQ-020 SHALL provide rsN_data combinationally: wb_data when wb_we & wb_rd==rsN_addr & rsN_addr!=0 (write-through bypass), else stored value.
REQ-021 SHALL write wb_data into reg[wb_rd] on the clock edge when wb_we & wb_rd!=0.
REQ-022 SHALL compute effective busy(r) = busy[r] & ~(wb_we & wb_rd==r); same-cycle write-back resolves the hazard.
REQ-023 SHALL assert stall = iss_valid & (busy(rs1_addr) | busy(rs2_addr) | (iss_werf & busy(iss_rd))); the last term blocks WAW so at most one pending write per register.
REQ-024 SHALL treat issue as accepted when iss_valid & ~stall; on acceptance with iss_werf & iss_rd!=0, set busy[iss_rd] next edge.
REQ-025 SHALL clear busy[wb_rd] on the edge when wb_we & wb_rd!=0.
REQ-026 SHALL, on simultaneous clear (write-back) and set (accepted issue) of the same register, leave busy set (younger instruction wins).
REQ-027 SHALL set sb_err on the edge when wb_we & wb_rd!=0 & ~busy[wb_rd]; sb_err holds until reset; the write itself still occurs.
REQ-028 SHALL have zero-cycle read latency and one-cycle write/busy update latency; stall is purely combinational.

Reset
REQ-029 SHALL, while rst high, asynchronously clear all registers to 0, all busy bits to 0, and sb_err to 0.
REQ-030 SHALL therefore drive rs1_data=rs2_data=0, stall=0, sb_err=0 during reset; a reset mid-operation discards all pending state.
REQ-031 SHALL ignore wb_we and issue acceptance while rst high.

Structure
REQ-032 SHALL take XLEN, NREG, REG_AW from the shared core package (riscv_pkg); no local redefinition.
REQ-033 SHALL place busy bits, stall, and sb_err logic in one sub-module, reg_scoreboard; array and bypass stay in reg_file_sb.

Verification
REQ-034 SHALL cover: reset, then read all 32 addresses -> every rsN_data = 0, stall=0, sb_err=0.
REQ-035 SHALL cover: issue rd=5; next cycle rs1_addr=5 with iss_valid -> stall=1; wb_we rd=5 data=0xDEADBEEF same cycle -> stall=0, rs1_data=0xDEADBEEF.
REQ-036 SHALL cover: wb_we rd=0 data=0x12345678 -> rs1_addr=0 reads 0, no sb_err, busy[0] never set by issue to x0.
REQ-037 SHALL cover: busy[7] set; same cycle wb_we rd=7 and accepted issue rd=7 -> busy[7] remains 1, following read of x7 stalls.
REQ-038 SHALL cover: wb_we rd=9 with busy[9]=0 -> reg[9] written, sb_err=1 and stays 1 until rst.
REQ-039 SHALL cover: pending rd=3; issue iss_werf rd=3 -> stall=1 (WAW); assert rst mid-sequence -> busy cleared, stall=0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core package: architectural sizing for the integer register file and
// anything else that needs to agree on register width and count.
//
// Contents:
//   XLEN    - data width of an architectural register
//   NREG    - number of architectural registers (x0..x31)
//   REG_AW  - register-address width
//   reg_addr_t / xreg_t - convenience types at the default sizes
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xreg_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending (busy) bit per architectural register,
// the issue-stall decision and a sticky error flag for unexpected write-backs.
//
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   wb_we, wb_rd        - write-back enable / destination (clears busy)
//   rs1_addr, rs2_addr  - source registers of the instruction at issue
//   iss_valid           - decode presents an instruction
//   iss_werf, iss_rd    - issuing instruction writes iss_rd
//   stall               - issue blocked this cycle (combinational)
//   sb_err              - sticky: write-back hit a register that was not pending
module reg_scoreboard #(
  parameter int unsigned NREG   = riscv_pkg::NREG,
  parameter int unsigned REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic              iss_valid,
  input  logic              iss_werf,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              stall,
  output logic              sb_err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] iss_hit;
  logic [NREG-1:0] eff_busy;
  logic            accept;
  logic            sb_err_q, sb_err_d;

  // One-hot of the write-back destination; bit 0 never set so x0 is inert.
  always_comb begin
    wb_hit = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      wb_hit[r] = wb_we && (wb_rd == REG_AW'(r));
    end
  end

  // A write-back landing this cycle already resolves the hazard.
  assign eff_busy = busy_q & ~wb_hit;

  assign stall = iss_valid &&
                 (eff_busy[rs1_addr] || eff_busy[rs2_addr] ||
                  (iss_werf && eff_busy[iss_rd]));

  assign accept = iss_valid && !stall;

  // Kept in its own block: it depends on stall, which depends on wb_hit.
  always_comb begin
    iss_hit = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      iss_hit[r] = accept && iss_werf && (iss_rd == REG_AW'(r));
    end
  end

  always_comb begin
    // Set after clear: a younger issue to the same register keeps it pending.
    busy_d    = (busy_q & ~wb_hit) | iss_hit;
    busy_d[0] = 1'b0;
    sb_err_d  = sb_err_q || |(wb_hit & ~busy_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with write-through bypass and an attached scoreboard.
// x0 reads as zero and ignores writes. Reads are combinational; writes and
// busy updates take effect on the rising clock edge.
//
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   wb_we, wb_rd, wb_data - write-back port
//   rs1_addr, rs1_data  - read port 1
//   rs2_addr, rs2_data  - read port 2
//   iss_valid, iss_werf, iss_rd - issuing instruction
//   stall               - issue blocked this cycle
//   sb_err              - sticky scoreboard error
module reg_file_sb #(
  parameter int unsigned XLEN   = riscv_pkg::XLEN,
  parameter int unsigned NREG   = riscv_pkg::NREG,
  parameter int unsigned REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              iss_valid,
  input  logic              iss_werf,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              stall,
  output logic              sb_err
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wb_wr;

  assign wb_wr = wb_we && (wb_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wb_wr) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Bypass is gated by rst so the read ports show zero throughout reset even
  // if the write-back stage is still driving.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (wb_wr && (wb_rd == rs1_addr)) begin
      rs1_data = wb_data;
    end
    if (rst) begin
      rs1_data = '0;
    end
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (wb_wr && (wb_rd == rs2_addr)) begin
      rs2_data = wb_data;
    end
    if (rst) begin
      rs2_data = '0;
    end
  end

  reg_scoreboard #(
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .iss_valid (iss_valid),
    .iss_werf  (iss_werf),
    .iss_rd    (iss_rd),
    .stall     (stall),
    .sb_err    (sb_err)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb. Inputs change after the falling
// edge; outputs are sampled 1 time unit later, well before the next rising edge.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        iss_valid;
  logic        iss_werf;
  logic [4:0]  iss_rd;
  logic        stall;
  logic        sb_err;

  int n_checks;
  int n_fail;

  reg_file_sb dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .iss_valid (iss_valid),
    .iss_werf  (iss_werf),
    .iss_rd    (iss_rd),
    .stall     (stall),
    .sb_err    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iss_valid;
    logic        iss_werf;
    logic [4:0]  iss_rd;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] data,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic iv, input logic iw, input logic [4:0] ird);
    wb_we     = we;
    wb_rd     = rd;
    wb_data   = data;
    rs1_addr  = r1;
    rs2_addr  = r2;
    iss_valid = iv;
    iss_werf  = iw;
    iss_rd    = ird;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //        we  rd     data          rs1    rs2    iv  iw  ird    e_rs1         e_rs2         st  err
    // x0 write/issue is inert
    vecs[0]  = '{0, 5'd0, 32'h0,        5'd0,  5'd31, 0, 0, 5'd0,  32'h0,        32'h0,        0, 0};
    vecs[1]  = '{1, 5'd0, 32'h12345678, 5'd0,  5'd0,  1, 1, 5'd0,  32'h0,        32'h0,        0, 0};
    vecs[2]  = '{0, 5'd0, 32'h0,        5'd0,  5'd0,  1, 1, 5'd0,  32'h0,        32'h0,        0, 0};
    // RAW on x5 resolved by same-cycle write-back
    vecs[3]  = '{0, 5'd0, 32'h0,        5'd1,  5'd2,  1, 1, 5'd5,  32'h0,        32'h0,        0, 0};
    vecs[4]  = '{0, 5'd0, 32'h0,        5'd5,  5'd0,  1, 0, 5'd0,  32'h0,        32'h0,        1, 0};
    vecs[5]  = '{1, 5'd5, 32'hDEADBEEF, 5'd5,  5'd0,  1, 0, 5'd0,  32'hDEADBEEF, 32'h0,        0, 0};
    vecs[6]  = '{0, 5'd0, 32'h0,        5'd5,  5'd5,  1, 0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    // Simultaneous clear and set of x7: younger issue keeps it busy
    vecs[7]  = '{0, 5'd0, 32'h0,        5'd0,  5'd0,  1, 1, 5'd7,  32'h0,        32'h0,        0, 0};
    vecs[8]  = '{1, 5'd7, 32'h00000077, 5'd7,  5'd0,  1, 1, 5'd7,  32'h00000077, 32'h0,        0, 0};
    vecs[9]  = '{0, 5'd0, 32'h0,        5'd7,  5'd0,  1, 0, 5'd0,  32'h00000077, 32'h0,        1, 0};
    vecs[10] = '{0, 5'd0, 32'h0,        5'd0,  5'd7,  0, 0, 5'd0,  32'h0,        32'h00000077, 0, 0};
    vecs[11] = '{1, 5'd7, 32'h00000088, 5'd7,  5'd0,  0, 0, 5'd0,  32'h00000088, 32'h0,        0, 0};
    vecs[12] = '{0, 5'd0, 32'h0,        5'd7,  5'd0,  1, 0, 5'd0,  32'h00000088, 32'h0,        0, 0};
    // Unexpected write-back to x9: written, error sticky
    vecs[13] = '{1, 5'd9, 32'hA5A5A5A5, 5'd9,  5'd0,  0, 0, 5'd0,  32'hA5A5A5A5, 32'h0,        0, 0};
    vecs[14] = '{0, 5'd0, 32'h0,        5'd9,  5'd9,  0, 0, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 1};
    vecs[15] = '{0, 5'd0, 32'h0,        5'd5,  5'd7,  1, 1, 5'd12, 32'hDEADBEEF, 32'h00000088, 0, 1};

    // Reset with write-back driven: nothing may leak through
    rst = 1'b1;
    drive(1, 5'd9, 32'hFFFFFFFF, 5'd9, 5'd9, 1, 1, 5'd9);
    #2;
    check("rst_rs1_bypass", rs1_data, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_err", {31'b0, sb_err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 5'd0);

    // Every address reads zero after reset
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1_addr  = 5'(i);
      rs2_addr  = 5'(31 - i);
      iss_valid = 1'b1;
      #1;
      check("init_rs1", rs1_data, 32'h0);
      check("init_rs2", rs2_data, 32'h0);
      check("init_stall", {31'b0, stall}, 32'h0);
    end
    check("init_err", {31'b0, sb_err}, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data, vecs[i].rs1, vecs[i].rs2,
            vecs[i].iss_valid, vecs[i].iss_werf, vecs[i].iss_rd);
      #1;
      check($sformatf("v%0d_rs1", i), rs1_data, vecs[i].e_rs1);
      check($sformatf("v%0d_rs2", i), rs2_data, vecs[i].e_rs2);
      check($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
      check($sformatf("v%0d_err", i), {31'b0, sb_err}, {31'b0, vecs[i].e_err});
    end

    // WAW on x3, then asynchronous reset mid-cycle
    @(negedge clk);
    drive(0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 1, 5'd3);
    #1;
    check("waw_first_issue", {31'b0, stall}, 32'h0);
    @(negedge clk);
    drive(1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd0, 1, 1, 5'd3);
    #1;
    check("waw_stall", {31'b0, stall}, 32'h1);
    check("waw_bypass", rs1_data, 32'hCAFEF00D);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_stall", {31'b0, stall}, 32'h0);
    check("midrst_rs1", rs1_data, 32'h0);
    check("midrst_err", {31'b0, sb_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 5'd0, 32'h0, 5'd5, 5'd9, 1, 1, 5'd3);
    #1;
    check("postrst_stall", {31'b0, stall}, 32'h0);
    check("postrst_x5", rs1_data, 32'h0);
    check("postrst_x9", rs2_data, 32'h0);
    check("postrst_err", {31'b0, sb_err}, 32'h0);
    @(negedge clk);
    drive(0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 1, 5'd3);
    #1;
    check("postrst_waw", {31'b0, stall}, 32'h1);
    @(negedge clk);
    drive(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
